// File: rtl/bcrypt_pkg.sv
// Shared types for the bcrypt S-box bank arbiter: slot encoding, bank index and word count.
package bcrypt_pkg;

  typedef enum logic [2:0] {
    SLOT_IDLE,
    SLOT_RD,
    SLOT_WR,
    SLOT_HOST,
    SLOT_WR_HOST
  } arb_slot_t;

  typedef logic [1:0] bank_idx_t;

  localparam int SBOX_WORDS = 128;
  localparam int NUM_BANKS  = 4;

  // Round reads want one 32-bit half of a 64-bit {L,R} word; lo=0 picks L.
  function automatic logic [31:0] half_sel(input logic [63:0] word, input logic lo);
    return lo ? word[31:0] : word[63:32];
  endfunction

endpackage

// File: rtl/sbox_age_counter.sv
// Wait-age tracker for one arbitrated requester; flags promotion once it has waited LIMIT cycles.
module sbox_age_counter #(
  parameter int LIMIT = 8
) (
  input  logic clk_1,
  input  logic rst_l,
  input  logic req,
  input  logic gnt,
  output logic promoted
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] age_reg;
  logic [CW-1:0] age_next;

  always_comb begin
    age_next = age_reg;
    if (!req || gnt) begin
      age_next = '0;
    end else if (age_reg != CW'(LIMIT)) begin
      age_next = age_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_1 or negedge rst_l) begin
    if (!rst_l) begin
      age_reg <= '0;
    end else begin
      age_reg <= age_next;
    end
  end

  // A dropped request must not keep its stale age visible for the current decision.
  assign promoted = req && (age_reg == CW'(LIMIT));

endmodule

// File: rtl/sbox_bank_arbiter.sv
// Per-cycle arbiter sharing the four S-box SRAM banks between round reads, key write-back and host.
// Optional stall counter (perf_stall_cnt / perf_clr) is built when SBOX_ARB_PERF_EN is defined.
module sbox_bank_arbiter
  import bcrypt_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int AW           = $clog2(SBOX_WORDS)
) (
  input  logic          clk_1,
  input  logic          rst_l,
`ifdef SBOX_ARB_PERF_EN
  input  logic          perf_clr,
  output logic [15:0]   perf_stall_cnt,
`endif
  input  logic          rd_req,
  input  logic [31:0]   rd_addr,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [31:0]   rd_data0,
  output logic [31:0]   rd_data1,
  output logic [31:0]   rd_data2,
  output logic [31:0]   rd_data3,
  input  logic          wr_req,
  input  logic [1:0]    wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [63:0]   wr_data,
  output logic          wr_gnt,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [1:0]    host_bank,
  input  logic [AW-1:0] host_addr,
  input  logic [63:0]   host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [63:0]   host_rdata,
  output logic [3:0]    sram_cs,
  output logic [3:0]    sram_we,
  output logic [AW-1:0] sram_addr0,
  output logic [AW-1:0] sram_addr1,
  output logic [AW-1:0] sram_addr2,
  output logic [AW-1:0] sram_addr3,
  output logic [63:0]   sram_wdata0,
  output logic [63:0]   sram_wdata1,
  output logic [63:0]   sram_wdata2,
  output logic [63:0]   sram_wdata3,
  input  logic [63:0]   sram_rdata0,
  input  logic [63:0]   sram_rdata1,
  input  logic [63:0]   sram_rdata2,
  input  logic [63:0]   sram_rdata3
);

  arb_slot_t slot_reg;
  arb_slot_t slot_next;

  logic wr_prom;
  logic host_prom;
  logic same_bank;
  logic rd_go;
  logic wr_go;
  logic host_go;

  // ---------------------------------------------------------------- slot decision
  assign same_bank = (wr_bank == host_bank);

  always_comb begin
    slot_next = SLOT_IDLE;
    if (rd_req && !(wr_prom || host_prom)) begin
      slot_next = SLOT_RD;
    end else if (wr_req && host_req) begin
      if (!same_bank) begin
        slot_next = SLOT_WR_HOST;
      end else if (host_prom && !wr_prom) begin
        slot_next = SLOT_HOST;
      end else begin
        slot_next = SLOT_WR;
      end
    end else if (wr_req) begin
      slot_next = SLOT_WR;
    end else if (host_req) begin
      slot_next = SLOT_HOST;
    end
  end

  assign rd_go   = (slot_next == SLOT_RD);
  assign wr_go   = (slot_next == SLOT_WR)   || (slot_next == SLOT_WR_HOST);
  assign host_go = (slot_next == SLOT_HOST) || (slot_next == SLOT_WR_HOST);

  always_ff @(posedge clk_1 or negedge rst_l) begin
    if (!rst_l) begin
      slot_reg <= SLOT_IDLE;
    end else begin
      slot_reg <= slot_next;
    end
  end

  assign rd_gnt   = (slot_reg == SLOT_RD);
  assign wr_gnt   = (slot_reg == SLOT_WR)   || (slot_reg == SLOT_WR_HOST);
  assign host_gnt = (slot_reg == SLOT_HOST) || (slot_reg == SLOT_WR_HOST);

  sbox_age_counter #(.LIMIT(STARVE_LIMIT)) u_wr_age (
    .clk_1    (clk_1),
    .rst_l    (rst_l),
    .req      (wr_req),
    .gnt      (wr_go),
    .promoted (wr_prom)
  );

  sbox_age_counter #(.LIMIT(STARVE_LIMIT)) u_host_age (
    .clk_1    (clk_1),
    .rst_l    (rst_l),
    .req      (host_req),
    .gnt      (host_go),
    .promoted (host_prom)
  );

  // ---------------------------------------------------------------- bank drive + read return
  logic [AW-1:0] addr_q  [NUM_BANKS];
  logic [63:0]   wdata_q [NUM_BANKS];
  logic [63:0]   rdata_a [NUM_BANKS];
  logic [31:0]   rd_data_a [NUM_BANKS];

  logic      rd_v1_reg;
  logic      rd_v2_reg;
  logic      host_v1_reg;
  logic      host_v2_reg;
  bank_idx_t host_bank1_reg;
  bank_idx_t host_bank2_reg;

  assign rdata_a[0] = sram_rdata0;
  assign rdata_a[1] = sram_rdata1;
  assign rdata_a[2] = sram_rdata2;
  assign rdata_a[3] = sram_rdata3;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic          cs_next;
      logic          we_next;
      logic [AW-1:0] addr_next;
      logic [63:0]   wdata_next;
      logic          cs_reg;
      logic          we_reg;
      logic [AW-1:0] addr_reg;
      logic [63:0]   wdata_reg;
      logic          half1_reg;
      logic          half2_reg;

      // Byte gi of rd_addr addresses bank gi: bits [7:1] word, bit [0] half.
      always_comb begin
        cs_next    = 1'b0;
        we_next    = 1'b0;
        addr_next  = '0;
        wdata_next = '0;
        if (rd_go) begin
          cs_next   = 1'b1;
          addr_next = AW'(rd_addr[8*gi+1 +: 7]);
        end else if (wr_go && (wr_bank == bank_idx_t'(gi))) begin
          cs_next    = 1'b1;
          we_next    = 1'b1;
          addr_next  = wr_addr;
          wdata_next = wr_data;
        end else if (host_go && (host_bank == bank_idx_t'(gi))) begin
          cs_next    = 1'b1;
          we_next    = host_we;
          addr_next  = host_addr;
          wdata_next = host_we ? host_wdata : '0;
        end
      end

      always_ff @(posedge clk_1 or negedge rst_l) begin
        if (!rst_l) begin
          cs_reg    <= 1'b0;
          we_reg    <= 1'b0;
          addr_reg  <= '0;
          wdata_reg <= '0;
          half1_reg <= 1'b0;
          half2_reg <= 1'b0;
        end else begin
          cs_reg    <= cs_next;
          we_reg    <= we_next;
          addr_reg  <= addr_next;
          wdata_reg <= wdata_next;
          half1_reg <= rd_go ? rd_addr[8*gi] : 1'b0;
          half2_reg <= half1_reg;
        end
      end

      assign sram_cs[gi]   = cs_reg;
      assign sram_we[gi]   = we_reg;
      assign addr_q[gi]    = addr_reg;
      assign wdata_q[gi]   = wdata_reg;
      assign rd_data_a[gi] = rd_v2_reg ? half_sel(rdata_a[gi], half2_reg) : '0;
    end
  endgenerate

  assign sram_addr0  = addr_q[0];
  assign sram_addr1  = addr_q[1];
  assign sram_addr2  = addr_q[2];
  assign sram_addr3  = addr_q[3];
  assign sram_wdata0 = wdata_q[0];
  assign sram_wdata1 = wdata_q[1];
  assign sram_wdata2 = wdata_q[2];
  assign sram_wdata3 = wdata_q[3];

  // Two-stage shift: stage 1 lines up with cs, stage 2 with the SRAM's registered data.
  always_ff @(posedge clk_1 or negedge rst_l) begin
    if (!rst_l) begin
      rd_v1_reg      <= 1'b0;
      rd_v2_reg      <= 1'b0;
      host_v1_reg    <= 1'b0;
      host_v2_reg    <= 1'b0;
      host_bank1_reg <= '0;
      host_bank2_reg <= '0;
    end else begin
      rd_v1_reg      <= rd_go;
      rd_v2_reg      <= rd_v1_reg;
      host_v1_reg    <= host_go && !host_we;
      host_v2_reg    <= host_v1_reg;
      host_bank1_reg <= host_bank;
      host_bank2_reg <= host_bank1_reg;
    end
  end

  assign rd_valid    = rd_v2_reg;
  assign rd_data0    = rd_data_a[0];
  assign rd_data1    = rd_data_a[1];
  assign rd_data2    = rd_data_a[2];
  assign rd_data3    = rd_data_a[3];
  assign host_rvalid = host_v2_reg;
  assign host_rdata  = host_v2_reg ? rdata_a[host_bank2_reg] : '0;

`ifdef SBOX_ARB_PERF_EN
  // Only the aged requesters count as stalls; a one-cycle rd preemption is by design.
  logic        stall;
  logic [15:0] perf_reg;

  assign stall = (wr_req && !wr_go) || (host_req && !host_go);

  always_ff @(posedge clk_1 or negedge rst_l) begin
    if (!rst_l) begin
      perf_reg <= '0;
    end else if (perf_clr) begin
      perf_reg <= '0;
    end else if (stall && (perf_reg != 16'hFFFF)) begin
      perf_reg <= perf_reg + 16'd1;
    end
  end

  assign perf_stall_cnt = perf_reg;
`endif

endmodule

// File: tb/tb_sbox_bank_arbiter.sv
// Directed bench for sbox_bank_arbiter with a 4-bank registered-read SRAM model attached.
module tb_sbox_bank_arbiter;

  localparam int AW = 7;

  logic          clk_1;
  logic          rst_l;
  logic          rd_req;
  logic [31:0]   rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [31:0]   rd_data0, rd_data1, rd_data2, rd_data3;
  logic          wr_req;
  logic [1:0]    wr_bank;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic          wr_gnt;
  logic          host_req;
  logic          host_we;
  logic [1:0]    host_bank;
  logic [AW-1:0] host_addr;
  logic [63:0]   host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [63:0]   host_rdata;
  logic [3:0]    sram_cs;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_addr0, sram_addr1, sram_addr2, sram_addr3;
  logic [63:0]   sram_wdata0, sram_wdata1, sram_wdata2, sram_wdata3;
  logic [63:0]   sram_rdata0, sram_rdata1, sram_rdata2, sram_rdata3;
`ifdef SBOX_ARB_PERF_EN
  logic          perf_clr;
  logic [15:0]   perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  sbox_bank_arbiter #(.STARVE_LIMIT(8), .AW(AW)) dut (
    .clk_1       (clk_1),
    .rst_l       (rst_l),
`ifdef SBOX_ARB_PERF_EN
    .perf_clr       (perf_clr),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_gnt      (rd_gnt),
    .rd_valid    (rd_valid),
    .rd_data0    (rd_data0),
    .rd_data1    (rd_data1),
    .rd_data2    (rd_data2),
    .rd_data3    (rd_data3),
    .wr_req      (wr_req),
    .wr_bank     (wr_bank),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_gnt      (wr_gnt),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_bank   (host_bank),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .sram_cs     (sram_cs),
    .sram_we     (sram_we),
    .sram_addr0  (sram_addr0),
    .sram_addr1  (sram_addr1),
    .sram_addr2  (sram_addr2),
    .sram_addr3  (sram_addr3),
    .sram_wdata0 (sram_wdata0),
    .sram_wdata1 (sram_wdata1),
    .sram_wdata2 (sram_wdata2),
    .sram_wdata3 (sram_wdata3),
    .sram_rdata0 (sram_rdata0),
    .sram_rdata1 (sram_rdata1),
    .sram_rdata2 (sram_rdata2),
    .sram_rdata3 (sram_rdata3)
  );

  initial clk_1 = 1'b0;
  always #5 clk_1 = ~clk_1;

  // Background pattern: {A0+b, addr, C0+b, addr ^ 00FFFF}.
  function automatic logic [63:0] pat(input int b, input int a);
    return {8'hA0 + 8'(b), 24'(a), 8'hC0 + 8'(b), 24'(a) ^ 24'h00FFFF};
  endfunction

  logic [63:0]   mem   [4][128];
  logic [63:0]   mdout [4];
  logic [AW-1:0] m_addr  [4];
  logic [63:0]   m_wdata [4];

  assign m_addr[0] = sram_addr0;   assign m_addr[1] = sram_addr1;
  assign m_addr[2] = sram_addr2;   assign m_addr[3] = sram_addr3;
  assign m_wdata[0] = sram_wdata0; assign m_wdata[1] = sram_wdata1;
  assign m_wdata[2] = sram_wdata2; assign m_wdata[3] = sram_wdata3;
  assign sram_rdata0 = mdout[0];   assign sram_rdata1 = mdout[1];
  assign sram_rdata2 = mdout[2];   assign sram_rdata3 = mdout[3];

  always @(posedge clk_1) begin
    for (int b = 0; b < 4; b++) begin
      if (!rst_l) begin
        for (int a = 0; a < 128; a++) mem[b][a] <= pat(b, a);
        mdout[b] <= '0;
      end else if (sram_cs[b]) begin
        if (sram_we[b]) mem[b][m_addr[b]] <= m_wdata[b];
        else            mdout[b] <= mem[b][m_addr[b]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_1);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int rd_cnt;
    rst_l = 1'b0; rd_req = 1'b0; rd_addr = '0;
    wr_req = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    host_req = 1'b0; host_we = 1'b0; host_bank = '0; host_addr = '0; host_wdata = '0;
`ifdef SBOX_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (3) tick();
    check("reset_cs", 64'(sram_cs), 64'h0);
    check("reset_gnts", 64'({rd_gnt, wr_gnt, host_gnt}), 64'h0);
    check("reset_valids", 64'({rd_valid, host_rvalid}), 64'h0);
    rst_l = 1'b1;
    tick();

    // rd only: byte lanes 00,81,02,03
    rd_req = 1'b1; rd_addr = 32'h0302_8100;
    tick();
    rd_req = 1'b0;
    check("rd_gnt", 64'(rd_gnt), 64'h1);
    check("rd_cs", 64'(sram_cs), 64'hF);
    check("rd_we", 64'(sram_we), 64'h0);
    check("rd_addrs", {32'h0, 1'b0, sram_addr0, 1'b0, sram_addr1, 1'b0, sram_addr2, 1'b0, sram_addr3},
          64'h0000_0000_0040_0101);
    tick();
    check("rd_valid", 64'(rd_valid), 64'h1);
    check("rd_data0", 64'(rd_data0), 64'hA000_0000);
    check("rd_data1", 64'(rd_data1), 64'hC100_FFBF);
    check("rd_data2", 64'(rd_data2), 64'hA200_0001);
    check("rd_data3", 64'(rd_data3), 64'hC300_FFFE);
    tick();
    check("rd_valid_pulse", 64'(rd_valid), 64'h0);

    // reset while a read is in flight
    rd_req = 1'b1; rd_addr = 32'h0;
    tick();
    rd_req = 1'b0;
    check("rst_mid_gnt", 64'(rd_gnt), 64'h1);
    #2 rst_l = 1'b0;
    #1 check("rst_mid_async_cs", 64'(sram_cs), 64'h0);
    tick();
    check("rst_mid_valid_a", 64'(rd_valid), 64'h0);
    tick();
    check("rst_mid_valid_b", 64'(rd_valid), 64'h0);
    rst_l = 1'b1;
    tick();
    check("rst_mid_valid_c", 64'(rd_valid), 64'h0);

    // starvation: rd held, wr waits exactly 8 cycles
`ifdef SBOX_ARB_PERF_EN
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
`endif
    rd_req = 1'b1; rd_addr = 32'h0;
    tick();
    tick();
    wr_req = 1'b1; wr_bank = 2'd2; wr_addr = 7'd5; wr_data = 64'h1122_3344_5566_7788;
    k = 21; rd_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (wr_gnt) begin
        k = i;
        break;
      end
      if (rd_gnt) rd_cnt++;
    end
    wr_req = 1'b0;
    check("starve_wr_latency", 64'(k), 64'd9);
    check("starve_rd_during_wait", 64'(rd_cnt), 64'd8);
    check("starve_rd_preempted", 64'(rd_gnt), 64'h0);
    check("starve_cs_we", 64'({sram_cs, sram_we}), 64'h44);
    check("starve_addr2", 64'(sram_addr2), 64'd5);
    check("starve_wdata2", sram_wdata2, 64'h1122_3344_5566_7788);
    tick();
    check("starve_rd_resume", 64'({rd_gnt, wr_gnt}), 64'h2);
    rd_req = 1'b0;
    tick();
    tick();
`ifdef SBOX_ARB_PERF_EN
    check("perf_after_starve", 64'(perf_stall_cnt), 64'd8);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("perf_clr", 64'(perf_stall_cnt), 64'd0);
`endif

    // wr bank1 + host write bank3 together
    wr_req = 1'b1; wr_bank = 2'd1; wr_addr = 7'd3; wr_data = 64'hDEAD_BEEF_0000_0001;
    host_req = 1'b1; host_we = 1'b1; host_bank = 2'd3; host_addr = 7'd7;
    host_wdata = 64'hCAFE_F00D_1234_5678;
    tick();
    wr_req = 1'b0; host_req = 1'b0;
    check("pair_gnts", 64'({wr_gnt, host_gnt}), 64'h3);
    check("pair_we", 64'(sram_we), 64'hA);
    check("pair_cs", 64'(sram_cs), 64'hA);
    check("pair_addrs", 64'({1'b0, sram_addr1, 1'b0, sram_addr3}), 64'h0307);
    check("pair_wdata3", sram_wdata3, 64'hCAFE_F00D_1234_5678);
    tick();
    check("pair_gnts_done", 64'({wr_gnt, host_gnt}), 64'h0);

    // same bank 0: wr first, host read next, returns the written word
    wr_req = 1'b1; wr_bank = 2'd0; wr_addr = 7'd9; wr_data = 64'h0BAD_F00D_5555_AAAA;
    host_req = 1'b1; host_we = 1'b0; host_bank = 2'd0; host_addr = 7'd9;
    tick();
    wr_req = 1'b0;
    check("same_first", 64'({wr_gnt, host_gnt}), 64'h2);
    check("same_first_we", 64'(sram_we), 64'h1);
    tick();
    host_req = 1'b0;
    check("same_second", 64'({wr_gnt, host_gnt}), 64'h1);
    check("same_second_cswe", 64'({sram_cs, sram_we}), 64'h10);
    check("same_second_addr0", 64'(sram_addr0), 64'd9);
    tick();
    check("host_rvalid", 64'(host_rvalid), 64'h1);
    check("host_rdata_bank0", host_rdata, 64'h0BAD_F00D_5555_AAAA);
    tick();
    check("host_rvalid_pulse", 64'(host_rvalid), 64'h0);

    // host read back of the bank-3 write
    host_req = 1'b1; host_we = 1'b0; host_bank = 2'd3; host_addr = 7'd7;
    tick();
    host_req = 1'b0;
    tick();
    check("host_rdata_bank3", host_rdata, 64'hCAFE_F00D_1234_5678);

`ifdef SBOX_ARB_PERF_EN
    // continuous contention on one bank: every cycle has a waiting aged requester
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    rd_req = 1'b1; rd_addr = 32'h0;
    wr_req = 1'b1; wr_bank = 2'd0; wr_addr = 7'd1; wr_data = 64'h1;
    host_req = 1'b1; host_we = 1'b1; host_bank = 2'd0; host_addr = 7'd2; host_wdata = 64'h2;
    repeat (70000) tick();
    rd_req = 1'b0; wr_req = 1'b0; host_req = 1'b0;
    tick();
    check("perf_saturate", 64'(perf_stall_cnt), 64'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
